// File: rtl/inst_fetch_stage_pkg.sv
// inst_fetch_stage_pkg: shared constants for the IF stage
package inst_fetch_stage_pkg;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/inst_fetch_stage_pc_reg.sv
// inst_fetch_stage_pc_reg: PC register with branch > jump > stall > increment next-PC selection
module inst_fetch_stage_pc_reg
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_jump_en,
    input  logic [31:0] i_jump_target,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;

    // EX-stage branch is older than the ID-stage jump, so it wins
    assign w_next_pc = i_branch_taken ? (i_branch_target & ALIGN_MASK) :
                       i_jump_en      ? (i_jump_target & ALIGN_MASK)   :
                       i_stall        ? r_pc                           :
                                        r_pc + PC_INC;

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else     r_pc <= w_next_pc;
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/inst_fetch_stage.sv
// inst_fetch_stage: PC, IF/ID pipeline register and saturating fetch/bubble counters
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      o_pc,
    input  logic [31:0]      i_inst_in,
    input  logic             i_stall,
    input  logic             i_jump_en,
    input  logic [31:0]      i_jump_target,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_target,
    output logic [31:0]      o_if_id_inst,
    output logic [31:0]      o_if_id_pc4,
    output logic             o_if_id_valid,
    output logic [CNT_W-1:0] o_fetch_cnt,
    output logic [CNT_W-1:0] o_bubble_cnt
);
    logic [31:0]      w_pc;
    logic             w_redirect;
    logic             w_take;
    logic [31:0]      r_inst;
    logic [31:0]      r_pc4;
    logic             r_valid;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    inst_fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (i_stall),
        .i_jump_en       (i_jump_en),
        .i_jump_target   (i_jump_target),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .o_pc            (w_pc)
    );

    assign w_redirect = i_branch_taken | i_jump_en;
    assign w_take     = !w_redirect && !i_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst  <= NOP_INST;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (w_redirect) begin
            r_inst  <= NOP_INST;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_inst  <= i_inst_in;
            r_pc4   <= w_pc + PC_INC;
            r_valid <= 1'b1;
        end
    end

    // exactly one counter advances per cycle; both stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (w_take) begin
            if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
        end else begin
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign o_pc          = w_pc;
    assign o_if_id_inst  = r_inst;
    assign o_if_id_pc4   = r_pc4;
    assign o_if_id_valid = r_valid;
    assign o_fetch_cnt   = r_fetch_cnt;
    assign o_bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb_inst_fetch_stage: scoreboard bench comparing two IF-stage instances against a behavioural model
module tb_inst_fetch_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic        v;
        logic [31:0] f;
        logic [31:0] b;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] rom [64];

    logic [31:0] pc_a, inst_a, ifi_a, pc4_a;
    logic        v_a;
    logic [31:0] f_a, b_a;
    logic [31:0] pc_b, inst_b, ifi_b, pc4_b;
    logic        v_b;
    logic [3:0]  f_b, b_b;

    st_t m_a = '0, m_b = '0;
    st_t q_a[$], q_b[$];
    int  errors = 0, checks = 0;

    always #5 clk = ~clk;

    assign inst_a = rom[pc_a[7:2]];
    assign inst_b = rom[pc_b[7:2]];

    inst_fetch_stage u_a (
        .clk(clk), .rst(rst), .o_pc(pc_a), .i_inst_in(inst_a), .i_stall(stall),
        .i_jump_en(jump_en), .i_jump_target(jump_target), .i_branch_taken(branch_taken),
        .i_branch_target(branch_target), .o_if_id_inst(ifi_a), .o_if_id_pc4(pc4_a),
        .o_if_id_valid(v_a), .o_fetch_cnt(f_a), .o_bubble_cnt(b_a)
    );

    inst_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .o_pc(pc_b), .i_inst_in(inst_b), .i_stall(stall),
        .i_jump_en(jump_en), .i_jump_target(jump_target), .i_branch_taken(branch_taken),
        .i_branch_target(branch_target), .o_if_id_inst(ifi_b), .o_if_id_pc4(pc4_b),
        .o_if_id_valid(v_b), .o_fetch_cnt(f_b), .o_bubble_cnt(b_b)
    );

    function automatic logic [31:0] sat_inc(logic [31:0] c, logic [31:0] mx);
        return (c >= mx) ? mx : c + 32'd1;
    endfunction

    // one clock of the IF stage described by its rules, not its registers
    function automatic st_t step(st_t s, bit r, bit st, bit je, logic [31:0] jt, bit bt,
                                 logic [31:0] bg, logic [31:0] rp, logic [31:0] mx);
        st_t n = s;
        if (r) begin
            n = '0;
            n.pc = rp;
        end else if (bt || je) begin
            n.pc   = bt ? {bg[31:2], 2'b00} : {jt[31:2], 2'b00};
            n.inst = 32'h0;
            n.pc4  = 32'h0;
            n.v    = 1'b0;
            n.b    = sat_inc(s.b, mx);
        end else if (st) begin
            n.b = sat_inc(s.b, mx);
        end else begin
            n.inst = rom[s.pc[7:2]];
            n.pc4  = s.pc + 32'd4;
            n.v    = 1'b1;
            n.pc   = s.pc + 32'd4;
            n.f    = sat_inc(s.f, mx);
        end
        return n;
    endfunction

    task automatic drive(bit r, bit s, bit j, logic [31:0] jt, bit b, logic [31:0] bg);
        @(negedge clk);
        rst = r; stall = s; jump_en = j; jump_target = jt; branch_taken = b; branch_target = bg;
        m_a = step(m_a, r, s, j, jt, b, bg, 32'h0, 32'hFFFF_FFFF);
        m_b = step(m_b, r, s, j, jt, b, bg, 32'hFFFF_FFFC, 32'd15);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
    endtask

    task automatic compare(string name, st_t act, st_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pc=%h inst=%h pc4=%h v=%b f=%0d b=%0d, want pc=%h inst=%h pc4=%h v=%b f=%0d b=%0d",
                     name, act.pc, act.inst, act.pc4, act.v, act.f, act.b,
                     exp.pc, exp.inst, exp.pc4, exp.v, exp.f, exp.b);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q_a.size() != 0) compare("dut_a", {pc_a, ifi_a, pc4_a, v_a, f_a, b_a}, q_a.pop_front());
        if (q_b.size() != 0) compare("dut_b", {pc_b, ifi_b, pc4_b, v_b, 28'h0, f_b, 28'h0, b_b}, q_b.pop_front());
    end

    initial begin
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h0010_1464;
        rom[2] = 32'h2800_3826;
        rom[3] = 32'h3800_0C46;
        for (int i = 4; i < 64; i++) rom[i] = $urandom;
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h04, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h04, 1, 32'h08);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_000B, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 32'h40, 0, 0);
        drive(1, 1, 1, 32'h40, 1, 32'h80);
        repeat (20) drive(0, 0, 0, 0, 0, 0);
        repeat (20) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom, $urandom_range(0, 7) == 0, $urandom);
        drive(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
